// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_pkg
// Description : Shared integer-pipeline types, widths and operand-select helper.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

    localparam int XLEN      = 32;
    localparam int REG_IDX_W = 5;
    localparam int NUM_REGS  = 32;

    typedef logic [REG_IDX_W-1:0] reg_idx_t;
    typedef logic [XLEN-1:0]      xword_t;

    // x0 reads as zero; a same-cycle writeback to the source wins over the file.
    function automatic xword_t select_operand(
        input reg_idx_t rs,
        input logic     wb_valid,
        input reg_idx_t wb_rd,
        input xword_t   wb_data,
        input xword_t   rf_data
    );
        if (rs == '0)
            return '0;
        else if (wb_valid && (wb_rd == rs))
            return wb_data;
        else
            return rf_data;
    endfunction

endpackage
`default_nettype wire

// File: rtl/operand_fetch_if.sv
`default_nettype none
// ============================================================================
// Module      : operand_fetch_if
// Description : Decode, register-file, writeback and execute signals of operand fetch.
// Revision    : 1.0 - initial release
// ============================================================================
interface operand_fetch_if
    import cpu_pkg::*;
#(
    parameter int CNT_W = 32
);
    logic             flush;
    logic             id_valid;
    logic             id_ready;
    reg_idx_t         id_rs1;
    reg_idx_t         id_rs2;
    logic             id_rs1_used;
    logic             id_rs2_used;
    reg_idx_t         id_rd;
    logic             id_rd_we;
    logic             rf_r0_valid;
    logic             rf_r1_valid;
    reg_idx_t         rf_r0_ad;
    reg_idx_t         rf_r1_ad;
    xword_t           rf_r0_data;
    xword_t           rf_r1_data;
    logic             wb_valid;
    reg_idx_t         wb_rd;
    xword_t           wb_data;
    logic             rf_w_valid;
    reg_idx_t         rf_w_ad;
    xword_t           rf_w_data;
    logic             ex_valid;
    logic             ex_ready;
    xword_t           ex_rs1_data;
    xword_t           ex_rs2_data;
    reg_idx_t         ex_rd;
    logic             ex_rd_we;
    logic [CNT_W-1:0] stall_cnt;

    modport master (
        output flush, id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used, id_rd, id_rd_we,
        output rf_r0_data, rf_r1_data, wb_valid, wb_rd, wb_data, ex_ready,
        input  id_ready, rf_r0_valid, rf_r1_valid, rf_r0_ad, rf_r1_ad,
        input  rf_w_valid, rf_w_ad, rf_w_data,
        input  ex_valid, ex_rs1_data, ex_rs2_data, ex_rd, ex_rd_we, stall_cnt
    );

    modport slave (
        input  flush, id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used, id_rd, id_rd_we,
        input  rf_r0_data, rf_r1_data, wb_valid, wb_rd, wb_data, ex_ready,
        output id_ready, rf_r0_valid, rf_r1_valid, rf_r0_ad, rf_r1_ad,
        output rf_w_valid, rf_w_ad, rf_w_data,
        output ex_valid, ex_rs1_data, ex_rs2_data, ex_rd, ex_rd_we, stall_cnt
    );
endinterface
`default_nettype wire

// File: rtl/operand_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : operand_scoreboard
// Description : Busy bit per register with set/clear ports and RAW/WAW hazard queries.
// Revision    : 1.0 - initial release
// ============================================================================
module operand_scoreboard
    import cpu_pkg::*;
(
    input  wire logic                clk,
    input  wire logic                rst,
    input  wire logic                i_set_valid,
    input  wire reg_idx_t            i_set_idx,
    input  wire logic                i_clr_valid,
    input  wire reg_idx_t            i_clr_idx,
    input  wire reg_idx_t            i_rs1,
    input  wire logic                i_rs1_used,
    input  wire reg_idx_t            i_rs2,
    input  wire logic                i_rs2_used,
    input  wire reg_idx_t            i_rd,
    input  wire logic                i_rd_we,
    output logic                     o_hz1,
    output logic                     o_hz2,
    output logic                     o_hzw,
    output logic [NUM_REGS-1:0]      o_busy
);

    logic [NUM_REGS-1:0] r_busy;
    logic [NUM_REGS-1:0] w_set_mask;
    logic [NUM_REGS-1:0] w_clr_mask;
    logic [NUM_REGS-1:0] w_busy_nxt;

    // Set is applied after clear so an index retired and reissued in one cycle stays busy.
    always_comb begin
        w_set_mask = '0;
        w_clr_mask = '0;
        if (i_set_valid && (i_set_idx != '0))
            w_set_mask[i_set_idx] = 1'b1;
        if (i_clr_valid)
            w_clr_mask[i_clr_idx] = 1'b1;
        w_busy_nxt    = (r_busy & ~w_clr_mask) | w_set_mask;
        w_busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst)
            r_busy <= '0;
        else
            r_busy <= w_busy_nxt;
    end

    always_comb begin
        o_hz1 = i_rs1_used && r_busy[i_rs1] && !(i_clr_valid && (i_clr_idx == i_rs1));
        o_hz2 = i_rs2_used && r_busy[i_rs2] && !(i_clr_valid && (i_clr_idx == i_rs2));
        o_hzw = i_rd_we && (i_rd != '0) && r_busy[i_rd] && !(i_clr_valid && (i_clr_idx == i_rd));
    end

    assign o_busy = r_busy;

endmodule
`default_nettype wire

// File: rtl/operand_fetch.sv
`default_nettype none
// ============================================================================
// Module      : operand_fetch
// Description : Single-stage issue between decode and execute with hazard stall and bypass.
// Revision    : 1.0 - initial release
// ============================================================================
module operand_fetch
    import cpu_pkg::*;
#(
    parameter int CNT_W = 32
)(
    input  wire logic    clk,
    input  wire logic    rst,
    operand_fetch_if.slave bus
);

    logic                w_slot_free;
    logic                w_hz1;
    logic                w_hz2;
    logic                w_hzw;
    logic                w_hazard;
    logic                w_accept;
    logic                w_stall;
    logic [NUM_REGS-1:0] w_busy;

    logic                r_ex_valid;
    xword_t              r_ex_rs1_data;
    xword_t              r_ex_rs2_data;
    reg_idx_t            r_ex_rd;
    logic                r_ex_rd_we;
    logic [CNT_W-1:0]    r_stall_cnt;

    operand_scoreboard u_sb (
        .clk         (clk),
        .rst         (rst),
        .i_set_valid (w_accept && bus.id_rd_we),
        .i_set_idx   (bus.id_rd),
        .i_clr_valid (bus.wb_valid),
        .i_clr_idx   (bus.wb_rd),
        .i_rs1       (bus.id_rs1),
        .i_rs1_used  (bus.id_rs1_used),
        .i_rs2       (bus.id_rs2),
        .i_rs2_used  (bus.id_rs2_used),
        .i_rd        (bus.id_rd),
        .i_rd_we     (bus.id_rd_we),
        .o_hz1       (w_hz1),
        .o_hz2       (w_hz2),
        .o_hzw       (w_hzw),
        .o_busy      (w_busy)
    );

    always_comb begin
        w_slot_free = !r_ex_valid || bus.ex_ready;
        w_hazard    = w_hz1 || w_hz2 || w_hzw;
        w_accept    = bus.id_valid && w_slot_free && !w_hazard && !bus.flush;
        w_stall     = bus.id_valid && w_slot_free && w_hazard && !bus.flush;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ex_valid    <= 1'b0;
            r_ex_rs1_data <= '0;
            r_ex_rs2_data <= '0;
            r_ex_rd       <= '0;
            r_ex_rd_we    <= 1'b0;
            r_stall_cnt   <= '0;
        end else begin
            if (bus.flush)
                r_ex_valid <= 1'b0;
            else if (w_slot_free)
                r_ex_valid <= w_accept;
            if (w_accept) begin
                r_ex_rs1_data <= select_operand(bus.id_rs1, bus.wb_valid, bus.wb_rd,
                                                bus.wb_data, bus.rf_r0_data);
                r_ex_rs2_data <= select_operand(bus.id_rs2, bus.wb_valid, bus.wb_rd,
                                                bus.wb_data, bus.rf_r1_data);
                r_ex_rd       <= bus.id_rd;
                r_ex_rd_we    <= bus.id_rd_we;
            end
            if (w_stall && (r_stall_cnt != '1))
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
    end

    assign bus.id_ready    = w_slot_free && !w_hazard && !bus.flush;
    assign bus.rf_r0_valid = bus.id_valid && bus.id_rs1_used;
    assign bus.rf_r1_valid = bus.id_valid && bus.id_rs2_used;
    assign bus.rf_r0_ad    = bus.id_rs1;
    assign bus.rf_r1_ad    = bus.id_rs2;
    assign bus.rf_w_valid  = bus.wb_valid && (bus.wb_rd != '0);
    assign bus.rf_w_ad     = bus.wb_rd;
    assign bus.rf_w_data   = bus.wb_data;
    assign bus.ex_valid    = r_ex_valid;
    assign bus.ex_rs1_data = r_ex_rs1_data;
    assign bus.ex_rs2_data = r_ex_rs2_data;
    assign bus.ex_rd       = r_ex_rd;
    assign bus.ex_rd_we    = r_ex_rd_we;
    assign bus.stall_cnt   = r_stall_cnt;

endmodule
`default_nettype wire

// File: tb/tb_operand_fetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_operand_fetch
// Description : Directed self-checking bench for operand_fetch.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_operand_fetch;
    import cpu_pkg::*;

    logic clk;
    logic rst;
    int   tests;
    int   failed;
    int   exp_stall;

    operand_fetch_if #(.CNT_W(32)) bus ();

    operand_fetch #(.CNT_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.flush = 0; bus.id_valid = 0; bus.id_rs1 = 0; bus.id_rs2 = 0;
        bus.id_rs1_used = 0; bus.id_rs2_used = 0; bus.id_rd = 0; bus.id_rd_we = 0;
        bus.rf_r0_data = 0; bus.rf_r1_data = 0; bus.wb_valid = 0; bus.wb_rd = 0;
        bus.wb_data = 0; bus.ex_ready = 1;
    endtask

    task automatic retire(input logic [4:0] idx);
        bus.wb_valid = 1; bus.wb_rd = idx; bus.wb_data = 32'h0;
        tick();
        bus.wb_valid = 0;
    endtask

    task automatic test_reset();
        tests++; if (bus.ex_valid !== 1'b0) begin failed++; $display("FAIL reset_ex_valid got %0h want 0", bus.ex_valid); end
        tests++; if (bus.ex_rs1_data !== 32'h0 || bus.ex_rs2_data !== 32'h0) begin failed++; $display("FAIL reset_ex_data got %h/%h want 0/0", bus.ex_rs1_data, bus.ex_rs2_data); end
        tests++; if (bus.ex_rd !== 5'd0 || bus.ex_rd_we !== 1'b0) begin failed++; $display("FAIL reset_ex_rd got %0d/%0d want 0/0", bus.ex_rd, bus.ex_rd_we); end
        tests++; if (bus.stall_cnt !== 32'd0) begin failed++; $display("FAIL reset_stall_cnt got %0d want 0", bus.stall_cnt); end
        tests++; if (dut.w_busy !== 32'h0) begin failed++; $display("FAIL reset_busy got %h want 0", dut.w_busy); end
        tests++; if (bus.rf_r0_valid !== 1'b0) begin failed++; $display("FAIL reset_rf_r0_valid got %0h want 0", bus.rf_r0_valid); end
        tick();
        tests++; if (bus.ex_valid !== 1'b0) begin failed++; $display("FAIL idle_ex_valid got %0h want 0", bus.ex_valid); end
    endtask

    task automatic test_raw_stall();
        bus.id_valid = 1; bus.id_rd = 5; bus.id_rd_we = 1;
        #1;
        tests++; if (bus.id_ready !== 1'b1) begin failed++; $display("FAIL raw_issue_ready got %0h want 1", bus.id_ready); end
        tick();
        tests++; if (bus.ex_valid !== 1'b1 || bus.ex_rd !== 5'd5 || bus.ex_rd_we !== 1'b1) begin failed++; $display("FAIL raw_issue_ex got v=%0h rd=%0d we=%0h want 1/5/1", bus.ex_valid, bus.ex_rd, bus.ex_rd_we); end
        tests++; if (dut.w_busy !== 32'h0000_0020) begin failed++; $display("FAIL raw_busy5 got %h want 00000020", dut.w_busy); end
        bus.id_rs1 = 5; bus.id_rs1_used = 1; bus.id_rd = 6; bus.id_rd_we = 0;
        bus.rf_r0_data = 32'h1111_1111;
        #1;
        tests++; if (bus.id_ready !== 1'b0) begin failed++; $display("FAIL raw_stall_ready got %0h want 0", bus.id_ready); end
        for (int i = 1; i <= 3; i++) begin
            tick();
            exp_stall++;
            tests++; if (bus.stall_cnt !== 32'(exp_stall)) begin failed++; $display("FAIL raw_stall_cnt got %0d want %0d", bus.stall_cnt, exp_stall); end
        end
        bus.wb_valid = 1; bus.wb_rd = 5; bus.wb_data = 32'hDEAD_BEEF;
        #1;
        tests++; if (bus.id_ready !== 1'b1) begin failed++; $display("FAIL raw_wb_ready got %0h want 1", bus.id_ready); end
        tick();
        bus.wb_valid = 0; bus.id_valid = 0;
        tests++; if (bus.ex_valid !== 1'b1 || bus.ex_rs1_data !== 32'hDEAD_BEEF) begin failed++; $display("FAIL raw_bypass got v=%0h d=%h want 1/deadbeef", bus.ex_valid, bus.ex_rs1_data); end
        tests++; if (bus.stall_cnt !== 32'(exp_stall) || dut.w_busy !== 32'h0) begin failed++; $display("FAIL raw_after got cnt=%0d busy=%h want %0d/0", bus.stall_cnt, dut.w_busy, exp_stall); end
        tick();
        idle_inputs();
    endtask

    task automatic test_x0();
        bus.id_valid = 1; bus.id_rs1 = 0; bus.id_rs2 = 0; bus.id_rs1_used = 1; bus.id_rs2_used = 1;
        bus.rf_r0_data = 32'hFFFF_FFFF; bus.rf_r1_data = 32'hFFFF_FFFF;
        bus.id_rd = 0; bus.id_rd_we = 1;
        bus.wb_valid = 1; bus.wb_rd = 0; bus.wb_data = 32'h55;
        #1;
        tests++; if (bus.rf_r0_valid !== 1'b1 || bus.rf_r1_valid !== 1'b1 || bus.rf_r0_ad !== 5'd0) begin failed++; $display("FAIL x0_read_port got %0h/%0h/%0d want 1/1/0", bus.rf_r0_valid, bus.rf_r1_valid, bus.rf_r0_ad); end
        tests++; if (bus.rf_w_valid !== 1'b0) begin failed++; $display("FAIL x0_write_suppress got %0h want 0", bus.rf_w_valid); end
        tick();
        tests++; if (bus.ex_rs1_data !== 32'h0 || bus.ex_rs2_data !== 32'h0) begin failed++; $display("FAIL x0_operands got %h/%h want 0/0", bus.ex_rs1_data, bus.ex_rs2_data); end
        tests++; if (dut.w_busy !== 32'h0) begin failed++; $display("FAIL x0_busy got %h want 0", dut.w_busy); end
        bus.id_rs1 = 3; bus.id_rs2 = 4; bus.rf_r0_data = 32'h1234_5678; bus.rf_r1_data = 32'hCAFE_F00D;
        bus.wb_valid = 1; bus.wb_rd = 3; bus.wb_data = 32'h0BAD_CAFE;
        #1;
        tests++; if (bus.rf_w_valid !== 1'b1 || bus.rf_w_ad !== 5'd3 || bus.rf_w_data !== 32'h0BAD_CAFE) begin failed++; $display("FAIL wport_pass got %0h/%0d/%h want 1/3/0badcafe", bus.rf_w_valid, bus.rf_w_ad, bus.rf_w_data); end
        tests++; if (bus.id_ready !== 1'b1 || bus.rf_r1_ad !== 5'd4) begin failed++; $display("FAIL x0_no_hazard got %0h/%0d want 1/4", bus.id_ready, bus.rf_r1_ad); end
        tick();
        tests++; if (bus.ex_rs1_data !== 32'h0BAD_CAFE || bus.ex_rs2_data !== 32'hCAFE_F00D) begin failed++; $display("FAIL mix_operands got %h/%h want 0badcafe/cafef00d", bus.ex_rs1_data, bus.ex_rs2_data); end
        idle_inputs();
        tick();
    endtask

    task automatic test_backpressure();
        bus.id_valid = 1; bus.id_rs1 = 2; bus.id_rs1_used = 1; bus.rf_r0_data = 32'hA5A5_A5A5;
        bus.id_rd = 10; bus.id_rd_we = 1;
        tick();
        bus.ex_ready = 0; bus.id_rs1 = 3; bus.rf_r0_data = 32'h5A5A_5A5A; bus.id_rd = 11;
        for (int i = 0; i < 4; i++) begin
            #1;
            tests++; if (bus.id_ready !== 1'b0) begin failed++; $display("FAIL bp_ready got %0h want 0", bus.id_ready); end
            tick();
            tests++; if (bus.ex_valid !== 1'b1 || bus.ex_rd !== 5'd10 || bus.ex_rs1_data !== 32'hA5A5_A5A5 || bus.stall_cnt !== 32'(exp_stall)) begin failed++; $display("FAIL bp_hold got v=%0h rd=%0d d=%h cnt=%0d want 1/10/a5a5a5a5/%0d", bus.ex_valid, bus.ex_rd, bus.ex_rs1_data, bus.stall_cnt, exp_stall); end
        end
        bus.ex_ready = 1;
        #1;
        tests++; if (bus.id_ready !== 1'b1) begin failed++; $display("FAIL bp_release_ready got %0h want 1", bus.id_ready); end
        tick();
        bus.id_valid = 0;
        tests++; if (bus.ex_valid !== 1'b1 || bus.ex_rd !== 5'd11 || bus.ex_rs1_data !== 32'h5A5A_5A5A) begin failed++; $display("FAIL bp_next got v=%0h rd=%0d d=%h want 1/11/5a5a5a5a", bus.ex_valid, bus.ex_rd, bus.ex_rs1_data); end
        tests++; if (dut.w_busy !== 32'h0000_0C00) begin failed++; $display("FAIL bp_busy got %h want 00000c00", dut.w_busy); end
        retire(10);
        retire(11);
        tests++; if (dut.w_busy !== 32'h0) begin failed++; $display("FAIL bp_retired got %h want 0", dut.w_busy); end
        idle_inputs();
    endtask

    task automatic test_same_cycle_and_waw();
        bus.id_valid = 1; bus.id_rd = 7; bus.id_rd_we = 1;
        tick();
        bus.wb_valid = 1; bus.wb_rd = 7;
        #1;
        tests++; if (bus.id_ready !== 1'b1) begin failed++; $display("FAIL set_clr_ready got %0h want 1", bus.id_ready); end
        tick();
        bus.wb_valid = 0;
        tests++; if (dut.w_busy !== 32'h0000_0080 || bus.ex_rd !== 5'd7) begin failed++; $display("FAIL set_wins got busy=%h rd=%0d want 00000080/7", dut.w_busy, bus.ex_rd); end
        bus.id_rd = 9;
        tick();
        #1;
        tests++; if (bus.id_ready !== 1'b0) begin failed++; $display("FAIL waw_stall_ready got %0h want 0", bus.id_ready); end
        tick(); tick();
        exp_stall += 2;
        tests++; if (bus.stall_cnt !== 32'(exp_stall)) begin failed++; $display("FAIL waw_stall_cnt got %0d want %0d", bus.stall_cnt, exp_stall); end
        bus.wb_valid = 1; bus.wb_rd = 9;
        #1;
        tests++; if (bus.id_ready !== 1'b1) begin failed++; $display("FAIL waw_release got %0h want 1", bus.id_ready); end
        tick();
        bus.wb_valid = 0; bus.id_valid = 0;
        tests++; if (bus.ex_rd !== 5'd9 || dut.w_busy !== 32'h0000_0280) begin failed++; $display("FAIL waw_after got rd=%0d busy=%h want 9/00000280", bus.ex_rd, dut.w_busy); end
        retire(7);
        retire(9);
        idle_inputs();
    endtask

    task automatic test_flush();
        bus.id_valid = 1; bus.id_rd = 12; bus.id_rd_we = 1;
        tick();
        bus.id_rd = 13; bus.flush = 1;
        #1;
        tests++; if (bus.ex_valid !== 1'b1 || bus.id_ready !== 1'b0) begin failed++; $display("FAIL flush_pre got v=%0h rdy=%0h want 1/0", bus.ex_valid, bus.id_ready); end
        tick();
        bus.flush = 0; bus.id_valid = 0;
        tests++; if (bus.ex_valid !== 1'b0) begin failed++; $display("FAIL flush_kill got %0h want 0", bus.ex_valid); end
        tests++; if (dut.w_busy !== 32'h0000_1000 || bus.stall_cnt !== 32'(exp_stall)) begin failed++; $display("FAIL flush_busy got %h cnt=%0d want 00001000/%0d", dut.w_busy, bus.stall_cnt, exp_stall); end
        retire(12);
        idle_inputs();
    endtask

    task automatic test_reset_mid_stall();
        bus.id_valid = 1; bus.id_rd = 14; bus.id_rd_we = 1;
        tick();
        bus.id_rs1 = 14; bus.id_rs1_used = 1; bus.id_rd_we = 0;
        tick();
        rst = 1;
        tick();
        rst = 0; bus.id_valid = 0;
        tests++; if (bus.ex_valid !== 1'b0 || dut.w_busy !== 32'h0 || bus.stall_cnt !== 32'd0) begin failed++; $display("FAIL mid_reset got v=%0h busy=%h cnt=%0d want 0/0/0", bus.ex_valid, dut.w_busy, bus.stall_cnt); end
        idle_inputs();
    endtask

    initial begin
        tests = 0; failed = 0; exp_stall = 0;
        idle_inputs();
        rst = 1;
        tick(); tick();
        rst = 0;
        test_reset();
        test_raw_stall();
        test_x0();
        test_backpressure();
        test_same_cycle_and_waw();
        test_flush();
        test_reset_mid_stall();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/operand_fetch.md
Name: operand_fetch

Overview:
- Issue-side client of the integer register file: accepts decoded instructions, drives the two combinational read ports and the write port, and presents operands to execute.
- Tracks outstanding destination writes in a 32-entry scoreboard.
- Stalls decode on RAW/WAW hazards and bypasses same-cycle writeback data.
- One pipeline stage between decode and execute.

Parameters:
- xlen, 32, data width of register values.
- cnt_w, 32, width of saturating stall counter.

Ports:
- clk  in  1  clock (all state updates on rising edge).
- rst  in  1  synchronous, active-high reset.
- flush  in  1  kill instruction in output stage and input handshake this cycle.
- id_valid  in  1  decoded instruction present.
- id_ready  out  1  instruction accepted when id_valid&&id_ready.
- id_rs1, id_rs2  in  5  source register indices.
- id_rs1_used, id_rs2_used  in  1  source actually read.
- id_rd  in  5  destination index.
- id_rd_we  in  1  instruction writes rd.
- rf_r0_valid, rf_r1_valid  out  1  read-port enables (= id_valid && rsN_used).
- rf_r0_ad, rf_r1_ad  out  5  read addresses (= id_rs1, id_rs2).
- rf_r0_data, rf_r1_data  in  xlen  combinational read data, same cycle.
- wb_valid  in  1  writeback result present.
- wb_rd  in  5  writeback destination.
- wb_data  in  xlen  writeback value.
- rf_w_valid  out  1  = wb_valid && wb_rd!=0.
- rf_w_ad  out  5  = wb_rd.
- rf_w_data  out  xlen  = wb_data.
- ex_valid  out  1  operands valid to execute.
- ex_ready  in  1  execute accepts.
- ex_rs1_data, ex_rs2_data  out  xlen  operand values.
- ex_rd  out  5  destination index.
- ex_rd_we  out  1  destination write enable.
- stall_cnt  out  cnt_w  saturating count of hazard-stall cycles.

Behaviour:
- Reset: ex_valid=0, ex_rs1_data=ex_rs2_data=0, ex_rd=0, ex_rd_we=0, busy[31:0]=0, stall_cnt=0. Reset asserted mid-stall or mid-handshake drops everything; the cycle after deassertion starts empty.
- Output stage is a single register. slot_free = !ex_valid || ex_ready.
- busy[0] is constant 0. x0 is never hazarded, never written, and reads as 0 regardless of rf data.
- clr(r) = wb_valid && wb_rd==r.
- hz1 = id_rs1_used && busy[id_rs1] && !clr(id_rs1); hz2 likewise for rs2.
- hzw = id_rd_we && id_rd!=0 && busy[id_rd] && !clr(id_rd).
- hazard = hz1 || hz2 || hzw.
- id_ready = slot_free && !hazard && !flush (combinational).
- Operand select per source: rs==0 -> 0; else clr(rs) -> wb_data (bypass); else rf data.
- Accept (id_valid && id_ready): the output register loads operands, rd and rd_we; ex_valid=1 next cycle. Latency is 1 cycle.
- If slot_free and no accept: ex_valid=0 next cycle. If !slot_free: hold all outputs stable.
- flush: ex_valid=0 next cycle and nothing accepted. Scoreboard bits of already-issued instructions stay set (their writebacks still arrive). The bit being set by a flushed accept is never set, since no accept occurs.
- Scoreboard, per cycle:
  - Accepted instruction with rd_we && rd!=0 sets busy[rd].
  - wb_valid clears busy[wb_rd].
  - Same index set and cleared in one cycle: the set wins.
- wb_valid to an index with busy=0 is legal and leaves busy unchanged.
- stall_cnt increments when id_valid && slot_free && hazard && !flush, and saturates at all-ones.
- Write port is pass-through, with the wb_rd==0 write suppressed.
- At most one outstanding write per register, guaranteed by hzw.

Decomposition:
- Shared package cpu_pkg: xlen, reg index width (5), num regs (32), typedef reg_idx_t, typedef xword_t.
- One sub-module: operand_scoreboard. It holds the busy vector with set/clear ports and hazard query outputs for rs1/rs2/rd. It is reused by future issue logic.

Test Plan:
- Reset then idle: id_valid=0 -> ex_valid=0, busy=0, stall_cnt=0, rf_r0_valid=0.
- Issue rd=5 (rd_we=1), then next instruction reading rs1=5 with no wb -> id_ready=0 and stall_cnt counts 1,2,3. Drive wb_valid with wb_rd=5, wb_data=0xDEADBEEF -> same cycle id_ready=1 and ex_rs1_data=0xDEADBEEF next cycle.
- Read rs1=0 and rs2=0 with rf data forced to 0xFFFFFFFF -> both operands 0. rd=0 with rd_we=1 -> busy unchanged and no hazard later.
- Hold ex_ready=0 for 4 cycles with id_valid=1 -> ex_* stable, id_ready=0, stall_cnt unchanged. Release -> next instruction loads in 1 cycle.
- Same-cycle wb_rd=7 and accept of a new rd=7 writer -> busy[7]=1 afterwards. A WAW writer to busy rd=9 -> stalled until wb_rd=9.
- flush while ex_valid=1 and id_valid=1 -> ex_valid=0 next cycle, no accept, and prior busy bits retained.
